// File: rtl/weight_fetch_seq.sv
// Purpose : steps one weight store through phases 0..last_phase of a layer and hands each assembled weight vector downstream.
// Latency : start -> first ws_load is 2 cycles; each phase is SETUP(1) + fetch cycles + PRESENT(>=1), i.e. 8 cycles with a 6-cycle store fill.
// Backpressure: w_valid holds with ws_load high (store output frozen) until w_ready; abort wins over everything.
module weight_fetch_seq #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] layer,
    input  logic [2:0] last_phase,
    input  logic       abort,
    output logic       ws_load,
    output logic [3:0] ws_cs,
    output logic [2:0] ws_phase,
    input  logic       ws_valid,
    output logic       w_valid,
    input  logic       w_ready,
    output logic [2:0] w_phase,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        FETCH   = 3'd2,
        PRESENT = 3'd3,
        FINISH  = 3'd4
    } state_t;

    // Last fetch-counter value before the run is abandoned.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    // The store only drops a stale valid on its first load cycle, so the
    // first two fetch cycles cannot be trusted.
    localparam logic [TO_W-1:0] VLD_MIN = TO_W'(2);

    state_t          state;
    logic [2:0]      last_q;
    logic [TO_W-1:0] fetch_cnt;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_q    <= 3'd0;
            fetch_cnt <= '0;
            ws_load   <= 1'b0;
            ws_cs     <= 4'd0;
            ws_phase  <= 3'd0;
            w_valid   <= 1'b0;
            w_phase   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                ws_load <= 1'b0;
                w_valid <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        ws_load <= 1'b0;
                        if (start) begin
                            ws_cs    <= layer;
                            last_q   <= last_phase;
                            ws_phase <= 3'd0;
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            state    <= SETUP;
                        end
                    end
                    SETUP: begin
                        // load stays low this cycle so the store re-latches its address
                        fetch_cnt <= '0;
                        ws_load   <= 1'b1;
                        state     <= FETCH;
                    end
                    FETCH: begin
                        if (ws_valid && (fetch_cnt >= VLD_MIN)) begin
                            w_valid   <= 1'b1;
                            w_phase   <= ws_phase;
                            fetch_cnt <= fetch_cnt + 1'b1;
                            state     <= PRESENT;
                        end else if (fetch_cnt == TO_LAST) begin
                            err     <= 1'b1;
                            ws_load <= 1'b0;
                            state   <= FINISH;
                        end else begin
                            fetch_cnt <= fetch_cnt + 1'b1;
                        end
                    end
                    PRESENT: begin
                        if (w_ready) begin
                            w_valid <= 1'b0;
                            ws_load <= 1'b0;
                            if (ws_phase == last_q) begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end else begin
                                ws_phase <= ws_phase + 3'd1;
                                state    <= SETUP;
                            end
                        end
                    end
                    FINISH: begin
                        ws_load <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                    default: begin
                        ws_load <= 1'b0;
                        w_valid <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_fetch_seq.sv
module tb_weight_fetch_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] layer = 4'd0;
    logic [2:0] last_phase = 3'd0;
    logic       abort = 1'b0;
    logic       ws_load;
    logic [3:0] ws_cs;
    logic [2:0] ws_phase;
    logic       ws_valid;
    logic       w_valid;
    logic       w_ready = 1'b1;
    logic [2:0] w_phase;
    logic       busy;
    logic       done;
    logic       err;

    weight_fetch_seq #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer(layer),
        .last_phase(last_phase), .abort(abort), .ws_load(ws_load),
        .ws_cs(ws_cs), .ws_phase(ws_phase), .ws_valid(ws_valid),
        .w_valid(w_valid), .w_ready(w_ready), .w_phase(w_phase),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Weight-store model: valid cleared on first load cycle, set after 5 load
    // cycles so it is seen on the 6th. mode 1 = valid stuck high, 2 = never.
    int   mode = 0;
    int   fill;
    logic st_valid;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= 1'b0;
            fill     <= 0;
        end else if (ws_load) begin
            if (fill == 0) st_valid <= 1'b0;
            if (fill == 4) st_valid <= 1'b1;
            fill <= fill + 1;
        end else begin
            fill <= 0;
        end
    end
    assign ws_valid = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : st_valid;

    // Scoreboard queues filled by the stimulus.
    typedef struct {
        logic [2:0] phase;
        logic [3:0] cs;
    } vec_t;
    vec_t exp_q[$];
    int   done_q[$];

    // Monitor: compares every accepted vector and every done pulse.
    always @(negedge clk) begin : monitor
        vec_t e;
        int   d;
        if (rst_n) begin
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_vector: actual phase=%0d required none", w_phase);
                end else begin
                    e = exp_q.pop_front();
                    chk("vec_phase", w_phase, e.phase);
                    chk("vec_cs", ws_cs, e.cs);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: actual cyc=%0d required none", cyc);
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d);
                end
            end
        end
    end

    task automatic do_start(input logic [3:0] l, input logic [2:0] lp, output int s);
        @(posedge clk);
        #1;
        start = 1'b1;
        layer = l;
        last_phase = lp;
        s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_wvalid(input int limit, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (w_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int  s;
        int  lowc;
        int  rises;
        bit  prev;
        bit  seen;
        bit  cs_ok;

        // Reset values
        #12;
        chk("rst_ws_load", ws_load, 0);
        chk("rst_ws_cs", ws_cs, 0);
        chk("rst_ws_phase", ws_phase, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single phase, layer 1
        do_start(4'd1, 3'd0, s);
        exp_q.push_back('{phase: 3'd0, cs: 4'd1});
        done_q.push_back(s + 9);
        cs_ok = 1'b1;
        while (cyc < s + 10) begin
            @(negedge clk);
            if (cyc == s + 2) chk("first_load", ws_load, 1);
            if (cyc <= s + 9 && ws_cs !== 4'd1) cs_ok = 1'b0;
        end
        chk("single_cs_stable", cs_ok, 1);

        // Full run 0..7 with an ignored start mid-run
        do_start(4'd3, 3'd7, s);
        for (int p = 0; p < 8; p++) exp_q.push_back('{phase: 3'(p), cs: 4'd3});
        done_q.push_back(s + 65);
        lowc = 0;
        rises = 0;
        prev = 1'b0;
        while (cyc < s + 65) begin
            @(negedge clk);
            if (busy && !ws_load) lowc++;
            if (ws_load && !prev) rises++;
            prev = ws_load;
            if (cyc == s + 20) begin
                start = 1'b1;
                layer = 4'd9;
                last_phase = 3'd0;
            end else begin
                start = 1'b0;
            end
        end
        chk("full_load_low_cycles", lowc, 9);
        chk("full_load_rises", rises, 8);
        chk("full_cs_kept", ws_cs, 3);
        wait_until(s + 67);

        // Backpressure: 5 cycles stalled in PRESENT
        w_ready = 1'b0;
        do_start(4'd2, 3'd1, s);
        exp_q.push_back('{phase: 3'd0, cs: 4'd2});
        exp_q.push_back('{phase: 3'd1, cs: 4'd2});
        done_q.push_back(s + 22);
        wait_wvalid(20, seen);
        chk("bp_wvalid_seen", seen, 1);
        chk("bp_wvalid_cycle", cyc, s + 8);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_wvalid_hold", w_valid, 1);
            chk("bp_load_hold", ws_load, 1);
            chk("bp_phase_hold", ws_phase, 0);
        end
        @(posedge clk);
        #1;
        w_ready = 1'b1;
        wait_until(s + 24);

        // Stale valid held high: no exit before fetch counter 2
        mode = 1;
        do_start(4'd4, 3'd0, s);
        exp_q.push_back('{phase: 3'd0, cs: 4'd4});
        done_q.push_back(s + 6);
        wait_until(s + 8);
        mode = 0;

        // Timeout then recovery
        mode = 2;
        do_start(4'd5, 3'd0, s);
        wait_until(s + 17);
        chk("to_err_before", err, 0);
        wait_until(s + 18);
        chk("to_err_set", err, 1);
        chk("to_busy_finish", busy, 1);
        wait_until(s + 19);
        chk("to_idle", busy, 0);
        chk("to_err_sticky", err, 1);
        mode = 0;
        do_start(4'd5, 3'd0, s);
        chk("to_err_cleared", err, 0);
        exp_q.push_back('{phase: 3'd0, cs: 4'd5});
        done_q.push_back(s + 9);
        wait_until(s + 11);

        // Abort in PRESENT
        w_ready = 1'b0;
        do_start(4'd6, 3'd0, s);
        wait_wvalid(20, seen);
        chk("ab_wvalid_seen", seen, 1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("ab_wvalid", w_valid, 0);
        chk("ab_load", ws_load, 0);
        chk("ab_busy", busy, 0);
        w_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Async reset mid-FETCH
        do_start(4'd7, 3'd0, s);
        wait_until(s + 4);
        chk("rs_in_fetch", ws_load, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_ws_load", ws_load, 0);
        chk("rs_ws_cs", ws_cs, 0);
        chk("rs_busy", busy, 0);
        chk("rs_w_valid", w_valid, 0);
        chk("rs_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        chk("sb_vectors_drained", exp_q.size(), 0);
        chk("sb_done_drained", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
